// File: rtl/riscv_config_pkg.sv
// Core-wide configuration defaults shared by the out-of-order backend.
package riscv_config_pkg;

  localparam int DEFAULT_NUM_DIV_UNITS = 2;
  localparam int DEFAULT_DIV_LATENCY   = 32;

endpackage

// File: rtl/riscv_ooo_types_pkg.sv
// Shared out-of-order backend types: divider unit state and per-unit slot record.
package riscv_ooo_types_pkg;

  // Slot fields are sized for the largest supported latency and ROB tag.
  localparam int DIV_CNT_W = 16;
  localparam int DIV_TAG_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_unit_state_e;

  typedef struct packed {
    div_unit_state_e        state;
    logic [DIV_CNT_W-1:0]   cnt;
    logic [DIV_TAG_W-1:0]   tag;
  } div_slot_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/riscv_div_unit_slot.sv
// One divider unit's occupancy tracker: IDLE/BUSY/DONE FSM, latency counter and ROB tag.
module riscv_div_unit_slot
  import riscv_ooo_types_pkg::*;
#(
  parameter int ROB_IDX_W   = 5,
  parameter int DIV_LATENCY = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 grant_i,
  input  logic [ROB_IDX_W-1:0] grant_tag_i,
  input  logic                 wb_ack_i,
  output logic                 start_o,
  output div_unit_state_e      state_o,
  output logic [ROB_IDX_W-1:0] tag_o
);

  div_slot_t slot_q, slot_d;
  logic      start_q, start_d;

  always_comb begin
    slot_d  = slot_q;
    start_d = 1'b0;
    if (flush_i) begin
      slot_d.state = IDLE;
    end else begin
      case (slot_q.state)
        IDLE: if (grant_i) begin
          slot_d.state = BUSY;
          slot_d.cnt   = DIV_CNT_W'(DIV_LATENCY - 1);
          slot_d.tag   = DIV_TAG_W'(grant_tag_i);
          start_d      = 1'b1;
        end
        BUSY: begin
          // Counter reaches zero on the last BUSY cycle, giving DIV_LATENCY BUSY cycles.
          if (slot_q.cnt == '0) slot_d.state = DONE;
          else                  slot_d.cnt   = slot_q.cnt - DIV_CNT_W'(1);
        end
        DONE: if (wb_ack_i) slot_d.state = IDLE;
        default: slot_d.state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q  <= '{state: IDLE, cnt: '0, tag: '0};
      start_q <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      start_q <= start_d;
    end
  end

  assign start_o = start_q;
  assign state_o = slot_q.state;
  assign tag_o   = ROB_IDX_W'(slot_q.tag);

endmodule

// File: rtl/riscv_div_unit_scheduler.sv
// Shares NUM_DIV_UNITS non-pipelined dividers among NUM_REQ RS ports: round-robin
// grant onto IDLE units, fixed-latency occupancy, and one-at-a-time CDB writeback.
module riscv_div_unit_scheduler
  import riscv_config_pkg::*;
  import riscv_ooo_types_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int NUM_DIV_UNITS = DEFAULT_NUM_DIV_UNITS,
  parameter  int DIV_LATENCY   = DEFAULT_DIV_LATENCY,
  parameter  int ROB_IDX_W     = 5,
  localparam int UNIT_W        = clog2_min1(NUM_DIV_UNITS),
  localparam int BCNT_W        = $clog2(NUM_DIV_UNITS + 1),
  localparam int RR_W          = clog2_min1(NUM_REQ)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               flush_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  input  logic [NUM_REQ*ROB_IDX_W-1:0]       req_rob_idx_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  output logic [NUM_DIV_UNITS-1:0]           unit_start_o,
  output logic [NUM_DIV_UNITS*ROB_IDX_W-1:0] unit_rob_idx_o,
  output logic                               wb_valid_o,
  output logic [ROB_IDX_W-1:0]               wb_rob_idx_o,
  output logic [UNIT_W-1:0]                  wb_unit_o,
  input  logic                               wb_ready_i,
  output logic [BCNT_W-1:0]                  busy_count_o
);

  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]       req_tag;
  logic [NUM_DIV_UNITS-1:0][ROB_IDX_W-1:0] unit_tag, grant_tag;
  div_unit_state_e [NUM_DIV_UNITS-1:0]     unit_state;
  logic [NUM_DIV_UNITS-1:0]                unit_grant, wb_sel_oh, wb_ack;
  logic [NUM_DIV_UNITS-1:0]                arb_free;
  logic                                    arb_placed;
  logic [RR_W:0]                           arb_sum;
  logic [RR_W-1:0]                         arb_port;
  logic [RR_W-1:0]                         rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]                      req_ready;
  logic                                    wb_any;
  logic [UNIT_W-1:0]                       wb_unit;
  logic [ROB_IDX_W-1:0]                    wb_tag;
  logic [BCNT_W-1:0]                       busy_cnt;

  assign req_tag = req_rob_idx_i;

  // Requesters in rr order each take the lowest still-unclaimed unit that was IDLE
  // at the start of the cycle; a unit finishing wb this cycle is not yet IDLE.
  always_comb begin
    unit_grant = '0;
    grant_tag  = '0;
    req_ready  = '0;
    rr_ptr_d   = rr_ptr_q;
    arb_placed = 1'b0;
    arb_sum    = '0;
    arb_port   = '0;
    for (int u = 0; u < NUM_DIV_UNITS; u++) arb_free[u] = (unit_state[u] == IDLE);
    if (!rst_i && !flush_i) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        arb_sum = {1'b0, rr_ptr_q} + (RR_W+1)'(i);
        if (arb_sum >= (RR_W+1)'(NUM_REQ)) arb_sum = arb_sum - (RR_W+1)'(NUM_REQ);
        arb_port   = arb_sum[RR_W-1:0];
        arb_placed = 1'b0;
        if (req_valid_i[arb_port]) begin
          for (int u = 0; u < NUM_DIV_UNITS; u++) begin
            if (!arb_placed && arb_free[u]) begin
              arb_placed    = 1'b1;
              arb_free[u]   = 1'b0;
              unit_grant[u] = 1'b1;
              grant_tag[u]  = req_tag[arb_port];
            end
          end
        end
        if (arb_placed) begin
          req_ready[arb_port] = 1'b1;
          rr_ptr_d = (arb_port == RR_W'(NUM_REQ - 1)) ? '0 : arb_port + RR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  for (genvar g = 0; g < NUM_DIV_UNITS; g++) begin : g_unit
    riscv_div_unit_slot #(
      .ROB_IDX_W   (ROB_IDX_W),
      .DIV_LATENCY (DIV_LATENCY)
    ) u_slot (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .grant_i     (unit_grant[g]),
      .grant_tag_i (grant_tag[g]),
      .wb_ack_i    (wb_ack[g]),
      .start_o     (unit_start_o[g]),
      .state_o     (unit_state[g]),
      .tag_o       (unit_tag[g])
    );
  end

  // Lowest-index DONE unit owns the CDB; the others keep their result.
  always_comb begin
    wb_any    = 1'b0;
    wb_unit   = '0;
    wb_tag    = '0;
    wb_sel_oh = '0;
    busy_cnt  = '0;
    for (int u = 0; u < NUM_DIV_UNITS; u++) begin
      if (unit_state[u] != IDLE) busy_cnt = busy_cnt + BCNT_W'(1);
      if (!wb_any && unit_state[u] == DONE) begin
        wb_any       = 1'b1;
        wb_unit      = UNIT_W'(u);
        wb_tag       = unit_tag[u];
        wb_sel_oh[u] = 1'b1;
      end
    end
  end

  assign wb_valid_o     = wb_any & ~flush_i;
  assign wb_ack         = wb_sel_oh & {NUM_DIV_UNITS{wb_valid_o & wb_ready_i}};
  assign wb_rob_idx_o   = wb_tag;
  assign wb_unit_o      = wb_unit;
  assign busy_count_o   = busy_cnt;
  assign req_ready_o    = req_ready;
  assign unit_rob_idx_o = unit_tag;

endmodule

// File: tb/tb_riscv_div_unit_scheduler.sv
// Bench for riscv_div_unit_scheduler: directed scenarios plus a cycle-level reference
// model expressed in absolute grant/done cycle numbers.
module tb_riscv_div_unit_scheduler;

  localparam int NR = 4;
  localparam int NU = 2;
  localparam int L  = 4;
  localparam int W  = 5;

  logic            clk = 1'b0, rst = 1'b0, flush = 1'b0, wb_ready = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*W-1:0] req_tag = '0;
  logic [NR-1:0]   req_ready;
  logic [NU-1:0]   ustart;
  logic [NU*W-1:0] utag;
  logic            wb_valid;
  logic [W-1:0]    wb_tag;
  logic [0:0]      wb_unit;
  logic [1:0]      busy;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  riscv_div_unit_scheduler #(
    .NUM_REQ(NR), .NUM_DIV_UNITS(NU), .DIV_LATENCY(L), .ROB_IDX_W(W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_rob_idx_i(req_tag), .req_ready_o(req_ready),
    .unit_start_o(ustart), .unit_rob_idx_o(utag),
    .wb_valid_o(wb_valid), .wb_rob_idx_o(wb_tag), .wb_unit_o(wb_unit),
    .wb_ready_i(wb_ready), .busy_count_o(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each unit is either free or holds a tag with known start/done cycles.
  int           m_cyc, m_rr;
  bit           m_occ   [NU];
  int           m_ready [NU];
  int           m_start [NU];
  logic [W-1:0] m_tag   [NU];

  logic [NR-1:0] e_rdy;
  int            e_gp [NU];
  bit            e_wbv;
  int            e_wbu, e_busy, e_rr;
  logic [W-1:0]  e_wbtag;

  task automatic model_eval();
    int p;
    bit placed;
    e_rdy = '0; e_wbv = 0; e_wbu = 0; e_wbtag = '0; e_busy = 0; e_rr = m_rr;
    for (int u = 0; u < NU; u++) begin
      e_gp[u] = -1;
      if (m_occ[u]) e_busy++;
    end
    if (!flush) begin
      for (int u = 0; u < NU; u++)
        if (!e_wbv && m_occ[u] && m_cyc >= m_ready[u]) begin
          e_wbv = 1; e_wbu = u; e_wbtag = m_tag[u];
        end
      for (int i = 0; i < NR; i++) begin
        p = (m_rr + i) % NR;
        if (req_valid[p]) begin
          placed = 0;
          for (int u = 0; u < NU; u++)
            if (!placed && !m_occ[u] && e_gp[u] < 0) begin placed = 1; e_gp[u] = p; end
          if (placed) begin e_rdy[p] = 1'b1; e_rr = (p + 1) % NR; end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_cyc = 0; m_rr = 0;
      for (int u = 0; u < NU; u++) begin
        m_occ[u] = 0; m_tag[u] = '0; m_ready[u] = 0; m_start[u] = -1;
      end
    end else begin
      model_eval();
      if (flush) begin
        for (int u = 0; u < NU; u++) m_occ[u] = 0;
      end else begin
        if (e_wbv && wb_ready) m_occ[e_wbu] = 0;
        for (int u = 0; u < NU; u++)
          if (e_gp[u] >= 0) begin
            m_occ[u]   = 1;
            m_tag[u]   = req_tag[e_gp[u]*W +: W];
            m_start[u] = m_cyc + 1;
            m_ready[u] = m_cyc + L + 1;
          end
        m_rr = e_rr;
      end
      m_cyc++;
    end
  end

  logic [NU-1:0]   x_start;
  logic [NU*W-1:0] x_utag;
  bit              fl_win = 0, seen7 = 0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_unit_start", 64'(ustart), 64'(0));
      chk("rst_unit_rob_idx", 64'(utag), 64'(0));
      chk("rst_wb_valid", 64'(wb_valid), 64'(0));
      chk("rst_wb_rob_idx", 64'(wb_tag), 64'(0));
      chk("rst_wb_unit", 64'(wb_unit), 64'(0));
      chk("rst_busy_count", 64'(busy), 64'(0));
    end else begin
      model_eval();
      for (int u = 0; u < NU; u++) begin
        x_start[u]       = m_occ[u] && (m_start[u] == m_cyc);
        x_utag[u*W +: W] = m_tag[u];
      end
      chk("req_ready", 64'(req_ready), 64'(e_rdy));
      chk("unit_start", 64'(ustart), 64'(x_start));
      chk("unit_rob_idx", 64'(utag), 64'(x_utag));
      chk("wb_valid", 64'(wb_valid), 64'(e_wbv));
      if (e_wbv) begin
        chk("wb_unit", 64'(wb_unit), 64'(e_wbu));
        chk("wb_rob_idx", 64'(wb_tag), 64'(e_wbtag));
      end
      chk("busy_count", 64'(busy), 64'(e_busy));
      if (fl_win && wb_valid && wb_tag == 5'd7) seen7 = 1;
    end
  end

  task automatic cyc_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [NR-1:0] v, input logic [W-1:0] t0, t1, t2, t3);
    req_valid = v;
    req_tag   = {t3, t2, t1, t0};
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; flush = 1'b0;
    cyc_step(); cyc_step();
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) begin
      req_valid = 4'($urandom); req_tag = 20'($urandom);
      flush = 1'($urandom); wb_ready = 1'($urandom);
      #1;
      chk("rst_rand_ready", 64'(req_ready), 64'(0));
      chk("rst_rand_wb_valid", 64'(wb_valid), 64'(0));
      cyc_step();
    end
    req_valid = '0; req_tag = '0; flush = 1'b0; wb_ready = 1'b0;
    rst = 1'b0;
    #1 chk("post_rst_busy", 64'(busy), 64'(0));

    // Single op, tag 5 on port 0.
    set_req(4'b0001, 5'd5, 5'd0, 5'd0, 5'd0); wb_ready = 1'b1;
    #1 chk("s1_ready_c0", 64'(req_ready), 64'b0001);
    cyc_step(); req_valid = '0;
    #1 chk("s1_start_c1", 64'(ustart), 64'b01);
    chk("s1_utag0_c1", 64'(utag[W-1:0]), 64'd5);
    repeat (3) cyc_step();
    #1 chk("s1_wb_c4", 64'(wb_valid), 64'd0);
    cyc_step();
    #1 chk("s1_wb_c5", 64'(wb_valid), 64'd1);
    chk("s1_wbtag_c5", 64'(wb_tag), 64'd5);
    chk("s1_wbunit_c5", 64'(wb_unit), 64'd0);
    cyc_step();
    #1 chk("s1_busy_c6", 64'(busy), 64'd0);

    // Contention: four ports, two units, rr from 0.
    do_reset();
    set_req(4'b1111, 5'd10, 5'd11, 5'd12, 5'd13);
    #1 chk("ct_ready_01", 64'(req_ready), 64'b0011);
    cyc_step(); req_valid = '0;
    #1 chk("ct_utag_01", 64'(utag), 64'({5'd11, 5'd10}));
    repeat (6) cyc_step();
    set_req(4'b1111, 5'd10, 5'd11, 5'd12, 5'd13);
    #1 chk("ct_ready_23", 64'(req_ready), 64'b1100);
    cyc_step(); req_valid = '0;
    #1 chk("ct_utag_23", 64'(utag), 64'({5'd13, 5'd12}));
    repeat (6) cyc_step();
    set_req(4'b1111, 5'd10, 5'd11, 5'd12, 5'd13);
    #1 chk("ct_ready_01b", 64'(req_ready), 64'b0011);
    cyc_step(); req_valid = '0;
    repeat (8) cyc_step();

    // Backpressure: both units DONE, CDB stalled for 10 cycles.
    do_reset();
    wb_ready = 1'b0;
    set_req(4'b0011, 5'd20, 5'd21, 5'd0, 5'd0);
    cyc_step(); req_valid = '0;
    repeat (4) cyc_step();
    set_req(4'b1111, 5'd1, 5'd2, 5'd3, 5'd4);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("bp_wb_unit", 64'(wb_unit), 64'd0);
      chk("bp_wb_tag", 64'(wb_tag), 64'd20);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_busy", 64'(busy), 64'd2);
      cyc_step();
    end
    req_valid = '0; wb_ready = 1'b1;
    repeat (3) cyc_step();
    #1 chk("bp_drained", 64'(busy), 64'd0);

    // Wb/grant overlap: the unit acked in W is granted only in W+1.
    wb_ready = 1'b0;
    set_req(4'b0100, 5'd0, 5'd0, 5'd9, 5'd0);
    #1 chk("ov_ready_p2", 64'(req_ready), 64'b0100);
    cyc_step();
    set_req(4'b1000, 5'd0, 5'd0, 5'd0, 5'd10);
    #1 chk("ov_ready_p3", 64'(req_ready), 64'b1000);
    cyc_step();
    set_req(4'b0001, 5'd11, 5'd0, 5'd0, 5'd0);
    #1 chk("ov_pending", 64'(req_ready), 64'd0);
    repeat (3) cyc_step();
    wb_ready = 1'b1;
    #1 chk("ov_no_grant_W", 64'(req_ready), 64'd0);
    chk("ov_wb_W", 64'(wb_valid), 64'd1);
    cyc_step();
    #1 chk("ov_grant_W1", 64'(req_ready), 64'b0001);
    cyc_step(); req_valid = '0;
    repeat (8) cyc_step();

    // Flush of an in-flight op, then flush gating a DONE result.
    do_reset();
    fl_win = 1;
    wb_ready = 1'b1;
    set_req(4'b0001, 5'd7, 5'd0, 5'd0, 5'd0);
    cyc_step(); req_valid = '0;
    cyc_step();
    flush = 1'b1; set_req(4'b0010, 5'd0, 5'd8, 5'd0, 5'd0);
    #1 chk("fl_ready_c2", 64'(req_ready), 64'd0);
    chk("fl_busy_c2", 64'(busy), 64'd1);
    cyc_step();
    flush = 1'b0;
    #1 chk("fl_busy_c3", 64'(busy), 64'd0);
    chk("fl_grant_c3", 64'(req_ready), 64'b0010);
    cyc_step(); req_valid = '0; wb_ready = 1'b0;
    repeat (4) cyc_step();
    #1 chk("fl_done_c8", 64'(wb_valid), 64'd1);
    chk("fl_done_tag", 64'(wb_tag), 64'd8);
    flush = 1'b1;
    #1 chk("fl_wb_gated", 64'(wb_valid), 64'd0);
    cyc_step(); flush = 1'b0; wb_ready = 1'b1;
    #1 chk("fl_busy_after", 64'(busy), 64'd0);
    repeat (8) cyc_step();
    fl_win = 0;
    chk("fl_no_tag7", 64'(seen7), 64'd0);

    // Asynchronous reset mid-operation.
    set_req(4'b0011, 5'd3, 5'd4, 5'd0, 5'd0);
    cyc_step(); req_valid = '0;
    cyc_step();
    req_valid = 4'hF;
    #2 rst = 1'b1;
    #1 chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_utag", 64'(utag), 64'd0);
    chk("ar_ready", 64'(req_ready), 64'd0);
    cyc_step(); rst = 1'b0; req_valid = '0;

    // Mixed traffic with occasional flushes, checked by the model.
    for (int k = 0; k < 150; k++) begin
      req_valid = 4'($urandom);
      req_tag   = 20'($urandom);
      wb_ready  = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 19) == 0);
      cyc_step();
    end
    req_valid = '0; flush = 1'b0; wb_ready = 1'b1;
    repeat (10) cyc_step();
    #1 chk("final_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
